// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word read at a time to the mmu,
// and queues returned words in a 2-entry buffer for decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_fault,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic        mem_signed,
  output logic [1:0]  mem_width,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  input  logic        mem_ready
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUED,
    WAIT,
    FAULT
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] word;
    logic            fault;
  } entry_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            discard;

  entry_t          fifo_q [DEPTH];
  logic            head;
  logic [1:0]      count;

  logic            push_c;
  logic            pop_c;
  entry_t          push_entry_c;
  logic            tail_c;
  logic [1:0]      count_nxt_c;
  logic            head_nxt_c;
  entry_t          head_entry_c;

  assign mem_write_enable = 1'b0;
  assign mem_signed       = 1'b0;
  assign mem_width        = 2'd3;
  assign mem_data_in      = '0;

  // Buffer push/pop decisions and the head entry as it will look next cycle.
  always_comb begin
    push_c       = 1'b0;
    push_entry_c = '0;
    pop_c        = instr_valid && instr_ready && !redirect_valid;
    if (!redirect_valid) begin
      case (state)
        IDLE: begin
          if (pc[1:0] != 2'b00 && count != 2'(DEPTH)) begin
            push_c             = 1'b1;
            push_entry_c.pc    = pc;
            push_entry_c.word  = '0;
            push_entry_c.fault = 1'b1;
          end
        end
        WAIT: begin
          if (mem_ready && !discard) begin
            push_c             = 1'b1;
            push_entry_c.pc    = req_pc;
            push_entry_c.word  = mem_data_out;
            push_entry_c.fault = 1'b0;
          end
        end
        default: ;
      endcase
    end
    tail_c       = head ^ count[0];
    count_nxt_c  = redirect_valid ? 2'd0 : count + 2'(push_c) - 2'(pop_c);
    head_nxt_c   = redirect_valid ? 1'b0 : head ^ pop_c;
    head_entry_c = (push_c && tail_c == head_nxt_c) ? push_entry_c : fifo_q[head_nxt_c];
  end

  // Instruction buffer storage and registered decode-facing outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      head        <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_fault <= 1'b0;
    end else begin
      count       <= count_nxt_c;
      head        <= head_nxt_c;
      if (push_c) begin
        fifo_q[tail_c] <= push_entry_c;
      end
      instr_valid <= (count_nxt_c != 2'd0);
      if (count_nxt_c != 2'd0) begin
        instr       <= head_entry_c.word;
        instr_pc    <= head_entry_c.pc;
        instr_fault <= head_entry_c.fault;
      end else begin
        instr       <= '0;
        instr_pc    <= '0;
        instr_fault <= 1'b0;
      end
    end
  end

  // Fetch FSM; a redirect during a transaction lets it finish and marks its data stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      req_pc          <= RESET_PC;
      discard         <= 1'b0;
      mem_read_enable <= 1'b0;
      mem_address     <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
          end else if (pc[1:0] != 2'b00) begin
            if (count != 2'(DEPTH)) begin
              state <= FAULT;
            end
          end else if (count != 2'(DEPTH) && mem_ready) begin
            mem_read_enable <= 1'b1;
            mem_address     <= pc;
            req_pc          <= pc;
            state           <= ISSUED;
          end
        end
        ISSUED: begin
          if (!mem_ready) begin
            mem_read_enable <= 1'b0;
            state           <= WAIT;
          end
          if (redirect_valid) begin
            discard <= 1'b1;
            pc      <= redirect_pc;
          end
        end
        WAIT: begin
          if (mem_ready) begin
            state <= IDLE;
            if (redirect_valid) begin
              discard <= 1'b0;
              pc      <= redirect_pc;
            end else if (discard) begin
              discard <= 1'b0;
            end else begin
              pc <= req_pc + 32'd4;
            end
          end else if (redirect_valid) begin
            discard <= 1'b1;
            pc      <= redirect_pc;
          end
        end
        FAULT: begin
          if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural mmu, directed corner cases,
// a redirect table, and a randomized phase against an in-order stream model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_fault;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic        mem_signed;
  logic [1:0]  mem_width;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out = 32'h0;
  logic        mem_ready = 1'b1;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .reset            (reset),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .instr_fault      (instr_fault),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_signed       (mem_signed),
    .mem_width        (mem_width),
    .mem_address      (mem_address),
    .mem_data_in      (mem_data_in),
    .mem_data_out     (mem_data_out),
    .mem_ready        (mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Behavioural mmu: accept while idle, stay busy for a latency, then return data.
  int          lat_fix = 5;
  int          mmu_cnt = 0;
  logic [31:0] mmu_addr = 32'h0;
  logic [31:0] acc_q[$];

  always @(posedge clk) begin
    if (reset) begin
      mem_ready <= 1'b1;
      mmu_cnt   <= 0;
    end else if (mem_ready) begin
      if (mem_read_enable) begin
        mem_ready <= 1'b0;
        mmu_cnt   <= (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
        mmu_addr  <= mem_address;
        acc_q.push_back(mem_address);
      end
    end else if (mmu_cnt == 1) begin
      mem_ready    <= 1'b1;
      mem_data_out <= mem_word(mmu_addr);
      mmu_cnt      <= 0;
    end else begin
      mmu_cnt <= mmu_cnt - 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Called just after a rising edge; ends just after a rising edge.
  task automatic do_redirect(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", 32'(instr_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic take(input string nm, input logic [31:0] epc, input logic [31:0] eword,
                      input logic efault);
    logic found;
    found = 1'b0;
    instr_ready = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (instr_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk({nm, "_found"}, 32'(found), 32'd1);
    chk({nm, "_pc"}, instr_pc, epc);
    chk({nm, "_instr"}, instr, eword);
    chk({nm, "_fault"}, 32'(instr_fault), 32'(efault));
    @(posedge clk); #1;
    instr_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] target;
    logic        fault;
    logic [31:0] pc2;
  } vec_t;

  vec_t tbl[6];

  logic [31:0] exp_pc;
  logic        fault_mode;
  logic        fault_done;
  logic        chk_after;
  int          pops;
  int          idle_hits;
  logic        ok;
  logic [31:0] t;
  logic [31:0] a0, a1;

  initial begin
    tbl[0] = '{32'h0000_0100, 1'b0, 32'h0000_0104};
    tbl[1] = '{32'h0000_0102, 1'b1, 32'h0};
    tbl[2] = '{32'h0000_0200, 1'b0, 32'h0000_0204};
    tbl[3] = '{32'hFFFF_FFFC, 1'b0, 32'h0000_0000};
    tbl[4] = '{32'h0000_0003, 1'b1, 32'h0};
    tbl[5] = '{32'h0000_1000, 1'b0, 32'h0000_1004};

    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_rd_en", 32'(mem_read_enable), 32'd0);
    chk("rst_addr", mem_address, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_fault", 32'(instr_fault), 32'd0);
    chk("const_we", 32'(mem_write_enable), 32'd0);
    chk("const_signed", 32'(mem_signed), 32'd0);
    chk("const_width", 32'(mem_width), 32'd3);
    chk("const_din", mem_data_in, 32'h0);

    // Backpressure: exactly two fetches with decode stalled.
    repeat (40) @(posedge clk);
    #1;
    chk("bp_count", 32'(acc_q.size()), 32'd2);
    a0 = (acc_q.size() > 0) ? acc_q[0] : 32'hDEAD_BEEF;
    a1 = (acc_q.size() > 1) ? acc_q[1] : 32'hDEAD_BEEF;
    chk("bp_addr0", a0, 32'h0);
    chk("bp_addr1", a1, 32'h4);
    acc_q.delete();
    take("first", 32'h0, 32'h0050_0093, 1'b0);
    take("second", 32'h4, mem_word(32'h4), 1'b0);

    // Redirect while the fetch at 8 is outstanding.
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!mem_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_busy", 32'(ok), 32'd1);
    @(posedge clk); #1;
    do_redirect(32'h0000_0100);
    take("redir_wait", 32'h100, mem_word(32'h100), 1'b0);
    a0 = (acc_q.size() > 0) ? acc_q[0] : 32'hDEAD_BEEF;
    a1 = (acc_q.size() > 1) ? acc_q[1] : 32'hDEAD_BEEF;
    chk("resume_addr", a0, 32'h8);
    chk("redir_addr", a1, 32'h100);

    // Redirect coinciding with a completion and a pop.
    do_redirect(32'h0000_0300);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (instr_valid && !mem_ready && mmu_cnt == 1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("coinc_setup", 32'(ok), 32'd1);
    @(posedge clk); #1;
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0400;
    @(negedge clk);
    chk("coinc_complete", 32'(mem_ready), 32'd1);
    chk("coinc_valid", 32'(instr_valid), 32'd1);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    @(negedge clk);
    chk("coinc_flush", 32'(instr_valid), 32'd0);
    @(posedge clk); #1;
    take("coinc_next", 32'h400, mem_word(32'h400), 1'b0);

    // Redirect table, including misaligned targets and PC wrap.
    for (int i = 0; i < 6; i++) begin
      do_redirect(tbl[i].target);
      take("tbl_head", tbl[i].target, tbl[i].fault ? 32'h0 : mem_word(tbl[i].target),
           tbl[i].fault);
      if (tbl[i].fault) begin
        idle_hits = 0;
        repeat (20) begin
          @(negedge clk);
          if (mem_read_enable || instr_valid) idle_hits++;
        end
        chk("fault_idle", 32'(idle_hits), 32'd0);
        @(posedge clk); #1;
      end else begin
        take("tbl_next", tbl[i].pc2, mem_word(tbl[i].pc2), 1'b0);
      end
    end

    // Randomized phase against an in-order stream model.
    lat_fix = 0;
    pops = 0;
    exp_pc = 32'h0;
    fault_mode = 1'b0;
    fault_done = 1'b0;
    chk_after = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      instr_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = (i == 0) || ($urandom_range(0, 39) == 0);
      if (i == 0) begin
        t = 32'h0000_0800;
      end else begin
        case ($urandom_range(0, 9))
          0: begin
            t = $urandom;
            if (t[1:0] == 2'b00) t[0] = 1'b1;
          end
          1: t = 32'hFFFF_FFF8;
          default: t = 32'($urandom_range(0, 16383)) << 2;
        endcase
      end
      redirect_pc = t;
      @(negedge clk);
      if (chk_after) begin
        chk("rnd_flush", 32'(instr_valid), 32'd0);
        chk_after = 1'b0;
      end
      if (mem_read_enable && mem_ready) begin
        chk("rnd_align", 32'(mem_address[1:0]), 32'd0);
      end
      if (redirect_valid) begin
        exp_pc = redirect_pc;
        fault_mode = (redirect_pc[1:0] != 2'b00);
        fault_done = 1'b0;
        chk_after = 1'b1;
      end else if (instr_valid && instr_ready) begin
        pops++;
        if (fault_mode) begin
          chk("rnd_extra", 32'(fault_done), 32'd0);
          chk("rnd_fpc", instr_pc, exp_pc);
          chk("rnd_finstr", instr, 32'h0);
          chk("rnd_ffault", 32'(instr_fault), 32'd1);
          fault_done = 1'b1;
        end else begin
          chk("rnd_pc", instr_pc, exp_pc);
          chk("rnd_instr", instr, mem_word(exp_pc));
          chk("rnd_fault", 32'(instr_fault), 32'd0);
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
    redirect_valid = 1'b0;
    chk("rnd_progress", 32'(pops > 200), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the `mmu`. It owns the program counter and issues word-wide, unsigned read requests to the `mmu` one at a time. It captures each returned word into a 2-entry instruction buffer and presents it to decode over a valid/ready handshake. It also handles PC redirects from branches and jumps, including a redirect that arrives while a memory transaction is outstanding, and misaligned redirect targets.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset (ROM base).

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `redirect_valid`  in  1: load `redirect_pc` into the PC and flush the stage.
- `redirect_pc`  in  32: new fetch address.
- `instr_valid`  out  1: buffer head is valid.
- `instr_ready`  in  1: decode accepts the head this cycle.
- `instr`  out  32: head instruction word.
- `instr_pc`  out  32: address of `instr`.
- `instr_fault`  out  1: head entry is a misaligned-fetch fault; `instr` = 0.
- `mem_read_enable`  out  1: read request to `mmu`.
- `mem_write_enable`  out  1: constant 0.
- `mem_signed`  out  1: constant 0.
- `mem_width`  out  2: constant `2'd3` (4 bytes).
- `mem_address`  out  32: request address.
- `mem_data_in`  out  32: constant 0.
- `mem_data_out`  in  32: `mmu` read data.
- `mem_ready`  in  1: `mmu` idle/complete indication.

## Operation
- **Memory protocol, per transaction**:
  - Issue: assert `mem_read_enable` with `mem_address` while `mem_ready`=1.
  - Accept: hold both until `mem_ready` is seen 0.
  - Complete: the next cycle with `mem_ready`=1; `mem_data_out` is sampled in that cycle.
  - At most one transaction is outstanding.
- **FSM states**:
  - IDLE: if `pc[1:0]`≠0, push a fault entry (`instr`=0, `instr_fault`=1, `instr_pc`=pc) and go FAULT. Else, if `count`<2 and `mem_ready`=1, drive the request with `mem_address`=pc, latch `req_pc`=pc, go ISSUED.
  - ISSUED: `mem_read_enable`=1; on `mem_ready`=0, drop `mem_read_enable` and go WAIT.
  - WAIT: on `mem_ready`=1, either push {`req_pc`, `mem_data_out`, fault=0}, or drop the data if `discard`=1 (then clear `discard`). In both cases go IDLE. On a push, pc ← `req_pc`+4.
  - FAULT: no requests; leave only on redirect or reset.
- **PC arithmetic**: 32-bit, modulo 2^32, so `32'hFFFF_FFFC`+4 = 0.
- **Buffer**: 2-entry FIFO with a `count` register. Pop when `instr_valid`&&`instr_ready`. A push never finds the buffer full, because issue requires `count`<2 and only one transaction is outstanding. Push and pop in the same cycle keep `count` unchanged.
- **Redirect** (highest priority, acts in the cycle `redirect_valid`=1):
  - Buffer flushed (`count`←0); any pop or push in that cycle is ignored.
  - pc ← `redirect_pc`.
  - In ISSUED or WAIT: `discard`←1 and the transaction runs to completion. If completion coincides with the redirect, the data is dropped and the FSM goes IDLE.
  - In IDLE or FAULT: next state IDLE; no request issued that cycle.
- **Reset**: pc←`RESET_PC`, FSM←IDLE, `count`←0, `discard`←0. Reset mid-transaction abandons it; no response is tracked.

## Timing
- **Reset values**: `mem_read_enable`=0, `mem_address`=`RESET_PC`, `instr_valid`=0, `instr`=0, `instr_pc`=0, `instr_fault`=0. Constant outputs hold their fixed values.
- **Outputs**: all registered. `instr_valid` = (`count`≠0), registered.
- **Latency**:
  - `mem_read_enable` rises one cycle after the IDLE decision.
  - A pushed entry shows `instr_valid`=1 in the cycle after the completion cycle.
- **Redirect**: `instr_valid`=0 in the cycle after redirect. The first request to the new pc is issued no earlier than one cycle after the redirect, or after the outstanding completion, whichever is later.
- **Backpressure**: with `instr_ready`=0, fetching stops once `count`=2; fetching resumes in the cycle after a pop.

## Test plan
- **Reset fetch**: reset, `RESET_PC`=0, `mmu` model returns `32'h00500093` at 0 → first request `mem_address`=0; entry `instr`=`32'h00500093`, `instr_pc`=0; next request `mem_address`=4.
- **Backpressure**: `instr_ready`=0 → exactly 2 entries fetched (pc 0, 4); no third request. Raise `instr_ready` → entries popped in order 0, 4; fetch resumes at 8.
- **Redirect while WAIT**: redirect to `32'h0000_0100` while the request at 8 is outstanding → word from 8 never appears; next request `mem_address`=`32'h100`; first valid `instr_pc`=`32'h100`.
- **Redirect coincident with completion and a pop**: `count` = 0 afterwards, completion data dropped, the next entry delivered has `instr_pc`=`redirect_pc`.
- **Misaligned redirect**: redirect to `32'h0000_0102` → no `mem_read_enable`; an entry with `instr_fault`=1, `instr`=0, `instr_pc`=`32'h102`; stage idle until redirect to `32'h200` resumes normal fetch.
- **Wrap**: redirect to `32'hFFFF_FFFC` → after that fetch, next `mem_address`=0.
